// File: rtl/bpu_pkg.sv
// Shared helpers for the branch predictor: index sizing and saturating-counter encodings.
package bpu_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Weakly not-taken sits just below the MSB flip, weakly taken just above it.
    function automatic int ctr_wnt(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int ctr_wt(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int ctr_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating up/down counter with synchronous clear-to-reset-value and load.
// Clear beats load, load beats inc/dec; simultaneous inc and dec hold.
module sat_counter #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_q
);
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (i_clr) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_inc && !i_dec && r_q != MAX) begin
            r_q <= r_q + W'(1);
        end else if (i_dec && !i_inc && r_q != '0) begin
            r_q <= r_q - W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target table: zero-latency lookup for fetch, trained from ID.
// Reports mispredicts combinationally with the corrected PC and counts them (saturating).
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [PC_W-1:0] lu_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [PC_W-1:0] correct_pc,
    output logic [15:0]     mispredict_cnt
);
    localparam int IDX_W = clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;
    localparam logic [CTR_W-1:0] C_WNT = CTR_W'(ctr_wnt(CTR_W));
    localparam logic [CTR_W-1:0] C_WT  = CTR_W'(ctr_wt(CTR_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [PC_W-1:0]    r_target [ENTRIES];
    logic [CTR_W-1:0]   w_ctr    [ENTRIES];
    entry_t             w_tbl    [ENTRIES];

    logic [IDX_W-1:0] w_lu_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    entry_t           w_lu_e;
    logic             w_upd_hit;
    logic             w_upd_en;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_tbl[i] = '{valid: r_valid[i], tag: r_tag[i], target: r_target[i], ctr: w_ctr[i]};
        end
    end

    // Lookup sees only registered state, so a same-cycle update is not bypassed.
    assign w_lu_idx    = lu_pc[IDX_W-1:0];
    assign w_lu_e      = w_tbl[w_lu_idx];
    assign pred_hit    = w_lu_e.valid && (w_lu_e.tag == lu_pc[PC_W-1:IDX_W]);
    assign pred_taken  = pred_hit && w_lu_e.ctr[CTR_W-1];
    assign pred_target = pred_taken ? w_lu_e.target : lu_pc + PC_W'(1);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + PC_W'(1);

    assign w_upd_idx = upd_pc[IDX_W-1:0];
    assign w_upd_tag = upd_pc[PC_W-1:IDX_W];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_en  = upd_valid && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_upd_en && upd_taken) begin
            // Taken on a miss allocates over whatever aliased entry lives at this index.
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
        logic w_sel;
        assign w_sel = w_upd_en && (w_upd_idx == IDX_W'(gi));

        sat_counter #(
            .W       (CTR_W),
            .RST_VAL (C_WNT)
        ) u_ctr (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_clr      (flush),
            .i_load     (w_sel && !w_upd_hit && upd_taken),
            .i_load_val (C_WT),
            .i_inc      (w_sel && w_upd_hit && upd_taken),
            .i_dec      (w_sel && w_upd_hit && !upd_taken),
            .o_q        (w_ctr[gi])
        );
    end

    // Mispredicts are counted even during flush; the counter ignores flush.
    sat_counter #(
        .W       (16),
        .RST_VAL (16'h0000)
    ) u_mis_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (1'b0),
        .i_load     (1'b0),
        .i_load_val (16'h0000),
        .i_inc      (mispredict),
        .i_dec      (1'b0),
        .o_q        (mispredict_cnt)
    );

endmodule

// File: tb/tb_branch_predict_unit.sv
// Table-driven bench for branch_predict_unit with a queue of expected results per vector.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] lu_pc = '0;
    logic        pred_hit, pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [15:0] upd_pred_target = '0;
    logic        mispredict;
    logic [15:0] correct_pc;
    logic [15:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_W(16), .ENTRIES(16), .CTR_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .lu_pc           (lu_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .correct_pc      (correct_pc),
        .mispredict_cnt  (mispredict_cnt)
    );

    typedef struct {
        logic        fl;
        logic [15:0] lu;
        logic        uv;
        logic [15:0] upc;
        logic        ut;
        logic [15:0] utgt;
        logic        upt;
        logic [15:0] uptgt;
        logic        hit;
        logic        pt;
        logic [15:0] ptgt;
        logic        mis;
        logic [15:0] cpc;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];
    vec_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic fl, logic [15:0] lu, logic uv, logic [15:0] upc,
                                logic ut, logic [15:0] utgt, logic upt, logic [15:0] uptgt,
                                logic hit, logic pt, logic [15:0] ptgt, logic mis,
                                logic [15:0] cpc, logic [15:0] cnt);
        vec_t v;
        v = '{fl, lu, uv, upc, ut, utgt, upt, uptgt, hit, pt, ptgt, mis, cpc, cnt};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic hit, input logic pt,
                                 input logic [15:0] ptgt, input logic mis,
                                 input logic [15:0] cpc, input logic [15:0] cnt);
        n_vec++;
        chk({tag, ".pred_hit"},    16'(pred_hit),    16'(hit));
        chk({tag, ".pred_taken"},  16'(pred_taken),  16'(pt));
        chk({tag, ".pred_target"}, pred_target,      ptgt);
        chk({tag, ".mispredict"},  16'(mispredict),  16'(mis));
        chk({tag, ".correct_pc"},  correct_pc,       cpc);
        chk({tag, ".cnt"},         mispredict_cnt,   cnt);
    endtask

    task automatic idle_inputs();
        flush = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    endtask

    initial begin
        vec_t e;

        //             fl lu       uv upc      ut utgt     upt uptgt    hit pt ptgt     mis cpc      cnt
        tbl[0]  = mk(0, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0006, 0, 16'h0001, 16'd0);
        tbl[1]  = mk(0, 16'h0005, 1, 16'h0005, 1, 16'h0040, 0, 16'h0006, 0, 0, 16'h0006, 1, 16'h0040, 16'd0);
        tbl[2]  = mk(0, 16'h0005, 1, 16'h0005, 0, 16'h0000, 1, 16'h0040, 1, 1, 16'h0040, 1, 16'h0006, 16'd1);
        tbl[3]  = mk(0, 16'h0005, 1, 16'h0005, 0, 16'h0000, 0, 16'h0006, 1, 0, 16'h0006, 0, 16'h0006, 16'd2);
        tbl[4]  = mk(0, 16'h0005, 1, 16'h0005, 1, 16'h0040, 0, 16'h0006, 1, 0, 16'h0006, 1, 16'h0040, 16'd2);
        tbl[5]  = mk(0, 16'h0005, 1, 16'h0005, 1, 16'h0040, 0, 16'h0006, 1, 0, 16'h0006, 1, 16'h0040, 16'd3);
        tbl[6]  = mk(0, 16'h0005, 1, 16'h0005, 1, 16'h0040, 1, 16'h0040, 1, 1, 16'h0040, 0, 16'h0040, 16'd4);
        tbl[7]  = mk(0, 16'h0005, 1, 16'h0005, 1, 16'h0040, 1, 16'h0040, 1, 1, 16'h0040, 0, 16'h0040, 16'd4);
        tbl[8]  = mk(0, 16'h0005, 1, 16'h0005, 0, 16'h0000, 1, 16'h0040, 1, 1, 16'h0040, 1, 16'h0006, 16'd4);
        tbl[9]  = mk(0, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0001, 16'd5);
        tbl[10] = mk(0, 16'h0005, 1, 16'h0005, 1, 16'h0050, 1, 16'h0040, 1, 1, 16'h0040, 1, 16'h0050, 16'd5);
        tbl[11] = mk(0, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0050, 0, 16'h0001, 16'd6);
        tbl[12] = mk(0, 16'h0015, 1, 16'h0015, 1, 16'h0080, 0, 16'h0016, 0, 0, 16'h0016, 1, 16'h0080, 16'd6);
        tbl[13] = mk(0, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0006, 0, 16'h0001, 16'd7);
        tbl[14] = mk(0, 16'h0015, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0080, 0, 16'h0001, 16'd7);
        tbl[15] = mk(0, 16'h0003, 1, 16'h0003, 0, 16'h0000, 0, 16'h0004, 0, 0, 16'h0004, 0, 16'h0004, 16'd7);
        tbl[16] = mk(0, 16'h0003, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0004, 0, 16'h0001, 16'd7);
        tbl[17] = mk(1, 16'h0015, 1, 16'h0007, 1, 16'h0090, 0, 16'h0008, 1, 1, 16'h0080, 1, 16'h0090, 16'd7);
        tbl[18] = mk(0, 16'h0015, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0016, 0, 16'h0001, 16'd8);
        tbl[19] = mk(0, 16'h0007, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0008, 0, 16'h0001, 16'd8);
        tbl[20] = mk(0, 16'hFFFF, 1, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'd8);

        // State while reset is held.
        lu_pc = 16'h0005;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_outputs("in_reset", 1'b0, 1'b0, 16'h0006, 1'b0, 16'h0001, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            flush = tbl[i].fl; lu_pc = tbl[i].lu; upd_valid = tbl[i].uv;
            upd_pc = tbl[i].upc; upd_taken = tbl[i].ut; upd_target = tbl[i].utgt;
            upd_pred_taken = tbl[i].upt; upd_pred_target = tbl[i].uptgt;
            exp_q.push_back(tbl[i]);
            #3;
            e = exp_q.pop_front();
            check_outputs($sformatf("vec%0d", i), e.hit, e.pt, e.ptgt, e.mis, e.cpc, e.cnt);
        end

        // Long mispredict stream: count must pin at FFFF rather than wrap.
        @(negedge clk);
        idle_inputs();
        upd_valid = 1'b1; upd_pc = 16'h0020; upd_taken = 1'b1;
        upd_target = 16'h0100; upd_pred_taken = 1'b0; upd_pred_target = 16'h0021;
        lu_pc = 16'h0000;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        #1 check_outputs("sat_run", 1'b0, 1'b0, 16'h0001, 1'b1, 16'h0100, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        lu_pc = 16'h0020;
        #1 check_outputs("sat_hold", 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0001, 16'hFFFF);

        // Asynchronous reset mid-cycle clears table and counter immediately.
        #1 rst_n = 1'b0;
        #1 check_outputs("async_rst", 1'b0, 1'b0, 16'h0021, 1'b0, 16'h0001, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check_outputs("post_rst", 1'b0, 1'b0, 16'h0021, 1'b0, 16'h0001, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
